fwd_sel_stage: RTL and testbench
================================

FWD_SEL_STAGE -- requirements
Module: fwd_sel_stage

Interface
REQ-001 The parameter WIDTH SHALL default to 32 and set the data width of each input and the output.
REQ-002 The parameter NUM_IN SHALL default to 4, be legal from 2 to 16, and set the number of selectable inputs.
REQ-003 The parameter SEL_W SHALL default to 2, and SHALL satisfy 2^SEL_W >= NUM_IN.
REQ-004 Port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-005 Port resetn SHALL be an input, 1 bit wide, and be the reset: asynchronous, active-low.
REQ-006 Port in_data SHALL be an input, NUM_IN*WIDTH bits wide, carrying all candidate inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port in_sel SHALL be an input, SEL_W bits wide, and select which input is captured.
REQ-008 Port in_valid SHALL be an input, 1 bit wide, and indicate that a beat is offered upstream.
REQ-009 Port in_ready SHALL be an output, 1 bit wide, and indicate that the stage can accept a beat.
REQ-010 Port out_data SHALL be an output, WIDTH bits wide, carrying the head-entry data.
REQ-011 Port out_valid SHALL be an output, 1 bit wide, and indicate that the head entry is valid.
REQ-012 Port out_ready SHALL be an input, 1 bit wide, and indicate that downstream accepts the head entry.
REQ-013 Port flush SHALL be an input, 1 bit wide, and synchronously discard all stored entries.
REQ-014 Port bad_sel SHALL be an output, 1 bit wide, and be a sticky flag set by an accepted out-of-range select.

Function
REQ-015 Selection SHALL be: selected = input[in_sel] when in_sel < NUM_IN, else all-zero WIDTH bits.
REQ-016 The stage SHALL be a 2-entry in-order FIFO (skid buffer) of WIDTH-bit entries; occupancy count is 0..2.
REQ-017 A push SHALL occur when in_valid & in_ready; the selected value is stored.
REQ-018 A pop SHALL occur when out_valid & out_ready.
REQ-019 in_ready SHALL be 1 when count < 2, and depend only on registered state, with no combinational path from out_ready.
REQ-020 out_valid SHALL be 1 when count > 0; out_data SHALL equal the oldest entry, and be 0 when count == 0.
REQ-021 Latency from push to out_valid SHALL be 1 cycle; an accepted beat is never visible in its own cycle.
REQ-022 With count 1, a simultaneous push and pop SHALL leave count at 1, and the new beat SHALL become head next cycle.
REQ-023 With count 2, no push SHALL be possible; a pop alone SHALL reduce count to 1, and the second entry becomes head.
REQ-024 With count 0, a pop SHALL be impossible; out_ready is ignored.
REQ-025 Sustained in_valid=1 and out_ready=1 SHALL give one beat per cycle after the first-cycle fill.
REQ-026 Order SHALL be strictly FIFO; no entry SHALL be dropped or duplicated absent flush.
REQ-027 flush=1 SHALL set count to 0 next cycle, with priority over push and pop in the same cycle (the concurrent input beat is discarded, even if in_ready=1).
REQ-028 flush SHALL also clear bad_sel.
REQ-029 bad_sel SHALL set the cycle after a push with in_sel >= NUM_IN, and hold until flush or reset; the zero value is still stored.
REQ-030 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-031 resetn=0 SHALL immediately, without a clock, force: count=0, out_valid=0, out_data=0, in_ready=0, and bad_sel=0.
REQ-032 in_ready SHALL remain 0 while resetn=0, and rise to 1 on the first clk edge after deassertion.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries, and no stale beat SHALL appear after release.

Verification
REQ-034 Reset scenario: WIDTH=32, NUM_IN=4; in_data = {4,3,2,1} (input k = k+1); in_sel=2, in_valid=1, out_ready=1 -> out_data=3 with out_valid=1 one cycle later, then one beat per cycle.
REQ-035 Backpressure scenario: with out_ready=0, push in_sel=0 then in_sel=3 -> count=2 and in_ready=0; raise out_ready -> out_data=1, then 4 on consecutive cycles, with order preserved.
REQ-036 Out-of-range scenario: NUM_IN=3, SEL_W=2, in_sel=3 pushed -> stored out_data=0 and bad_sel=1 next cycle, holding until flush.
REQ-037 Flush scenario: count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, count=0, and bad_sel=0; the flushed-cycle beat never appears.
REQ-038 Async-reset scenario: assert resetn=0 between clk edges with count=1 -> out_valid drops without waiting for an edge; after release, out_valid stays 0 until a new push.

Source files
------------

// File: rtl/fwd_sel_stage_if.sv
// ---------------------------------------------------------------------------
// fwd_sel_stage_if
// Bus bundle for the forwarding-select skid stage.
//   in_data   : NUM_IN packed candidates, candidate k at [k*WIDTH +: WIDTH]
//   in_sel    : index of the candidate to capture
//   in_valid  : upstream offers a beat
//   in_ready  : stage can take a beat (registered)
//   out_data  : head entry data, zero when empty
//   out_valid : head entry present
//   out_ready : downstream takes the head entry
//   flush     : discard all stored entries and clear bad_sel
//   bad_sel   : sticky, set by an accepted out-of-range select
// master = producer/consumer side, slave = the stage itself.
// ---------------------------------------------------------------------------
interface fwd_sel_stage_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    flush;
    logic                    bad_sel;

    modport master (
        output in_data, in_sel, in_valid, out_ready, flush,
        input  in_ready, out_data, out_valid, bad_sel
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready, flush,
        output in_ready, out_data, out_valid, bad_sel
    );
endinterface

// File: rtl/fwd_sel_stage.sv
// ---------------------------------------------------------------------------
// fwd_sel_stage
// Selects one of NUM_IN candidate words and queues it in a 2-entry in-order
// skid buffer. in_ready comes from a register, so there is no combinational
// path from out_ready to in_ready.
//   clk    : single clock, rising edge
//   resetn : asynchronous active-low reset (control state only)
//   bus    : fwd_sel_stage_if.slave (data, select, handshakes, flush, bad_sel)
// ---------------------------------------------------------------------------
module fwd_sel_stage #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic            clk,
    input  logic            resetn,
    fwd_sel_stage_if.slave  bus
);
    // NUM_IN fits in SEL_W+1 bits because 2^SEL_W >= NUM_IN.
    localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_IN);

    logic signed [WIDTH-1:0] sel_data;
    logic                    sel_oob;

    logic [1:0]              count_q, count_d;
    logic                    in_ready_q, in_ready_d;
    logic                    bad_sel_q, bad_sel_d;
    logic signed [WIDTH-1:0] head_q, head_d;
    logic signed [WIDTH-1:0] tail_q, tail_d;

    logic                    push, pop;

    // Candidate select; out-of-range indices match no candidate and yield zero.
    always_comb begin
        sel_data = '0;
        sel_oob  = ({1'b0, bus.in_sel} >= NUM_IN_L);
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                sel_data = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign push = bus.in_valid & in_ready_q;
    assign pop  = (count_q != 2'd0) & bus.out_ready;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (bus.flush) begin
            // Flush wins over any concurrent push or pop.
            count_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d  = sel_data;
                        count_d = 2'd1;
                    end else begin
                        tail_d  = sel_data;
                        count_d = 2'd2;
                    end
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                // Push and pop together only happen at count 1: new beat replaces head.
                2'b11: head_d = sel_data;
                default: ;
            endcase
        end
        in_ready_d = (count_d != 2'd2);
        bad_sel_d  = bus.flush ? 1'b0 : (bad_sel_q | (push & sel_oob));
    end

    // Control registers: reset forces the stage empty and not ready.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
            bad_sel_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            bad_sel_q  <= bad_sel_d;
        end
    end

    // Data registers: contents are only observed through the count gate.
    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = (count_q != 2'd0) ? head_q : '0;
    assign bus.bad_sel   = bad_sel_q;
endmodule

// File: tb/tb_fwd_sel_stage.sv
module tb_fwd_sel_stage;
    localparam int W = 32;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    fwd_sel_stage_if #(.WIDTH(W), .NUM_IN(4), .SEL_W(2)) bus_a ();
    fwd_sel_stage_if #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) bus_b ();

    fwd_sel_stage #(.WIDTH(W), .NUM_IN(4), .SEL_W(2)) dut_a (
        .clk(clk), .resetn(resetn), .bus(bus_a.slave)
    );
    fwd_sel_stage #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) dut_b (
        .clk(clk), .resetn(resetn), .bus(bus_b.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] sb_q[$];
    bit           bad_exp    = 1'b0;
    bit           ready_live = 1'b0;

    typedef struct {
        logic         vld;
        logic [1:0]   sel;
        logic         ordy;
        logic         fl;
        logic         exp_vld;
        logic [W-1:0] exp_data;
        logic         exp_rdy;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(bit v, int s, bit o, bit f, bit ev, int ed, bit er);
        vec_t r;
        r.vld = v; r.sel = 2'(s); r.ordy = o; r.fl = f;
        r.exp_vld = ev; r.exp_data = W'(ed); r.exp_rdy = er;
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Candidate k of dut_a carries k+1.
    function automatic logic [W-1:0] sel_val_a(input logic [1:0] s);
        return W'(int'(s) + 1);
    endfunction

    task automatic drive_a(input logic v, input logic [1:0] s, input logic o, input logic f);
        @(negedge clk);
        bus_a.in_valid  = v;
        bus_a.in_sel    = s;
        bus_a.out_ready = o;
        bus_a.flush     = f;
        #1;
    endtask

    // Scoreboard compare against the queue, then apply this cycle's handshakes.
    task automatic model_a(input string tag);
        bit           push, pop, rdy_exp;
        logic [W-1:0] head_exp;
        rdy_exp  = ready_live && (sb_q.size() < 2);
        head_exp = '0;
        if (sb_q.size() > 0) head_exp = sb_q[0];
        check({tag, ".sb_out_valid"}, W'(bus_a.out_valid), W'(sb_q.size() > 0));
        check({tag, ".sb_out_data"},  bus_a.out_data, head_exp);
        check({tag, ".sb_in_ready"},  W'(bus_a.in_ready), W'(rdy_exp));
        check({tag, ".sb_bad_sel"},   W'(bus_a.bad_sel), W'(bad_exp));
        if (bus_a.flush) begin
            sb_q.delete();
            bad_exp = 1'b0;
        end else begin
            pop  = (sb_q.size() > 0) && bus_a.out_ready;
            push = bus_a.in_valid && rdy_exp;
            if (pop) void'(sb_q.pop_front());
            if (push) sb_q.push_back(sel_val_a(bus_a.in_sel));
        end
    endtask

    task automatic step_a(input logic v, input logic [1:0] s, input logic o, input logic f, input string tag);
        drive_a(v, s, o, f);
        model_a(tag);
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.in_data   = {32'd4, 32'd3, 32'd2, 32'd1};
        bus_a.in_sel    = 2'd0;
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b0;
        bus_a.flush     = 1'b0;
        bus_b.in_data   = {32'd3, 32'd2, 32'd1};
        bus_b.in_sel    = 2'd0;
        bus_b.in_valid  = 1'b0;
        bus_b.out_ready = 1'b0;
        bus_b.flush     = 1'b0;

        // Reset state
        #1 resetn = 1'b0;
        #1;
        check("rst.out_valid", W'(bus_a.out_valid), 0);
        check("rst.out_data",  bus_a.out_data, 0);
        check("rst.in_ready",  W'(bus_a.in_ready), 0);
        check("rst.bad_sel",   W'(bus_a.bad_sel), 0);
        check("rst_b.in_ready", W'(bus_b.in_ready), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hold.in_ready", W'(bus_a.in_ready), 0);
        resetn = 1'b1;
        #1;
        check("rst_rel.in_ready_before_edge", W'(bus_a.in_ready), 0);
        @(posedge clk);
        ready_live = 1'b1;

        //          vld sel ordy fl  ev data rdy
        vecs[0]  = mk(1, 2, 1, 0,   0, 0, 1);
        vecs[1]  = mk(1, 0, 1, 0,   1, 3, 1);
        vecs[2]  = mk(1, 3, 1, 0,   1, 1, 1);
        vecs[3]  = mk(1, 1, 1, 0,   1, 4, 1);
        vecs[4]  = mk(0, 0, 0, 0,   1, 2, 1);
        vecs[5]  = mk(1, 0, 0, 0,   1, 2, 1);
        vecs[6]  = mk(1, 3, 0, 0,   1, 2, 0);
        vecs[7]  = mk(0, 0, 1, 0,   1, 2, 0);
        vecs[8]  = mk(1, 3, 0, 0,   1, 1, 1);
        vecs[9]  = mk(0, 0, 1, 0,   1, 1, 0);
        vecs[10] = mk(0, 0, 1, 0,   1, 4, 1);
        vecs[11] = mk(0, 0, 1, 0,   0, 0, 1);
        vecs[12] = mk(1, 0, 0, 0,   0, 0, 1);
        vecs[13] = mk(1, 3, 0, 0,   1, 1, 1);
        vecs[14] = mk(0, 0, 0, 0,   1, 1, 0);
        vecs[15] = mk(0, 0, 1, 0,   1, 1, 0);
        vecs[16] = mk(0, 0, 1, 0,   1, 4, 1);
        vecs[17] = mk(1, 1, 0, 0,   0, 0, 1);
        vecs[18] = mk(1, 2, 0, 0,   1, 2, 1);
        vecs[19] = mk(1, 0, 0, 1,   1, 2, 0);
        vecs[20] = mk(1, 0, 0, 0,   0, 0, 1);
        vecs[21] = mk(1, 3, 1, 1,   1, 1, 1);
        vecs[22] = mk(0, 0, 1, 0,   0, 0, 1);

        for (int i = 0; i < 23; i++) begin
            drive_a(vecs[i].vld, vecs[i].sel, vecs[i].ordy, vecs[i].fl);
            check($sformatf("v%0d.out_valid", i), W'(bus_a.out_valid), W'(vecs[i].exp_vld));
            check($sformatf("v%0d.out_data", i),  bus_a.out_data, vecs[i].exp_data);
            check($sformatf("v%0d.in_ready", i),  W'(bus_a.in_ready), W'(vecs[i].exp_rdy));
            model_a($sformatf("v%0d", i));
            @(posedge clk);
        end

        // Asynchronous reset with one entry stored
        step_a(1, 2'd1, 0, 0, "ar_push");
        step_a(0, 2'd0, 0, 0, "ar_hold");
        #2 resetn = 1'b0;
        #1;
        check("ar.out_valid_no_edge", W'(bus_a.out_valid), 0);
        check("ar.out_data_no_edge",  bus_a.out_data, 0);
        check("ar.in_ready_no_edge",  W'(bus_a.in_ready), 0);
        sb_q.delete();
        bad_exp = 1'b0;
        ready_live = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ar.in_ready_held", W'(bus_a.in_ready), 0);
        resetn = 1'b1;
        #1;
        check("ar.out_valid_release", W'(bus_a.out_valid), 0);
        @(posedge clk);
        ready_live = 1'b1;
        for (int i = 0; i < 3; i++) step_a(0, 2'd0, 1, 0, $sformatf("ar_idle%0d", i));
        step_a(1, 2'd3, 1, 0, "ar_new");
        step_a(0, 2'd0, 1, 0, "ar_drain");
        step_a(0, 2'd0, 1, 0, "ar_empty");

        // Out-of-range select on the 3-input instance
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b1; bus_b.in_sel = 2'd3; bus_b.out_ready = 1'b0;
        #1;
        check("oob.bad_sel_before", W'(bus_b.bad_sel), 0);
        check("oob.in_ready", W'(bus_b.in_ready), 1);
        @(negedge clk);
        bus_b.in_valid = 1'b1; bus_b.in_sel = 2'd1; bus_b.out_ready = 1'b1;
        #1;
        check("oob.out_valid", W'(bus_b.out_valid), 1);
        check("oob.out_data_zero", bus_b.out_data, 0);
        check("oob.bad_sel_set", W'(bus_b.bad_sel), 1);
        @(negedge clk);
        bus_b.in_valid = 1'b1; bus_b.in_sel = 2'd2; bus_b.out_ready = 1'b1;
        #1;
        check("oob.next_data", bus_b.out_data, 2);
        check("oob.bad_sel_hold", W'(bus_b.bad_sel), 1);
        @(negedge clk);
        bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0; bus_b.flush = 1'b1;
        #1;
        check("oob.inrange_data", bus_b.out_data, 3);
        check("oob.bad_sel_still", W'(bus_b.bad_sel), 1);
        @(negedge clk);
        bus_b.flush = 1'b0;
        #1;
        check("oob.flush_out_valid", W'(bus_b.out_valid), 0);
        check("oob.flush_bad_sel", W'(bus_b.bad_sel), 0);
        check("oob.flush_in_ready", W'(bus_b.in_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
